// File: rtl/pkt_ingress_filter.sv
// pkt_ingress_filter: store-and-forward ingress filter in front of the mmu.
// Accepts 512-bit beats tagged with a control code, buffers each packet until its
// final beat arrives and only then makes it visible to the read side. Malformed,
// oversized or overflowing packets are rewound out of the buffer and never emitted.
// Optional statistics counters are built only when PKT_INGRESS_STATS_EN is defined.
module pkt_ingress_filter #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned MAX_BEATS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid_pkt,
    input  logic [7:0]   in_pkt_ctl,
    input  logic [511:0] in_pkt_data,
    output logic         out_valid_pkt_fifo,
    output logic [7:0]   out_pkt_ctl_fifo,
    output logic [511:0] out_pkt_data_fifo,
    output logic [15:0]  pkt_ok_cnt,
    output logic [15:0]  pkt_drop_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(MAX_BEATS + 1);

    localparam logic [7:0] CtlInvalid = 8'h00;
    localparam logic [7:0] CtlStart   = 8'h01;
    localparam logic [7:0] CtlPayload = 8'h02;
    localparam logic [7:0] CtlEnd     = 8'h03;
    localparam logic [7:0] CtlSingle  = 8'h04;

    localparam logic [PW-1:0] PtrOne   = PW'(1);
    localparam logic [PW-1:0] PtrDepth = PW'(DEPTH);
    localparam logic [CW-1:0] CntOne   = CW'(1);
    localparam logic [CW-1:0] CntMax   = CW'(MAX_BEATS);

    typedef enum logic [1:0] {
        StIdle,
        StInPkt,
        StDiscard
    } wr_state_e;

    // Buffer storage: {ctl, data} per beat.
    logic [519:0] mem [DEPTH];

    wr_state_e     state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;

    logic          beat_in;
    logic          full_at_wr;
    logic          full_at_commit;
    logic          restart;
    logic          wr_en;
    logic [PW-1:0] wr_addr;
    logic          commit;
    logic [1:0]    drop_inc;

    logic          rd_empty;
    logic          rd_valid_q;
    logic [519:0]  rd_beat_q;

    assign beat_in = in_valid_pkt && (in_pkt_ctl != CtlInvalid);

    // Full is judged against the pre-edge read pointer, so a read on the same edge
    // does not create space for the write.
    assign full_at_wr     = ((wr_ptr_q - rd_ptr_q) == PtrDepth);
    assign full_at_commit = ((commit_ptr_q - rd_ptr_q) == PtrDepth);

    assign rd_empty = (rd_ptr_q == commit_ptr_q);

    // Write-side next state: packet framing, length check, overflow rewind and commit.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        wr_en        = 1'b0;
        wr_addr      = wr_ptr_q;
        restart      = 1'b0;
        commit       = 1'b0;
        drop_inc     = 2'd0;

        if (beat_in) begin
            unique case (state_q)
                StIdle: begin
                    restart = 1'b1;
                end
                StInPkt: begin
                    if (in_pkt_ctl == CtlPayload || in_pkt_ctl == CtlEnd) begin
                        if (beat_cnt_q >= CntMax) begin
                            // Oversized: an end beat closes the bad packet, a payload
                            // beat leaves the rest of it to be skipped.
                            wr_ptr_d = commit_ptr_q;
                            drop_inc = 2'd1;
                            state_d  = (in_pkt_ctl == CtlEnd) ? StIdle : StDiscard;
                        end else if (full_at_wr) begin
                            wr_ptr_d = commit_ptr_q;
                            drop_inc = 2'd1;
                            state_d  = StDiscard;
                        end else begin
                            wr_en      = 1'b1;
                            wr_addr    = wr_ptr_q;
                            wr_ptr_d   = wr_ptr_q + PtrOne;
                            beat_cnt_d = beat_cnt_q + CntOne;
                            if (in_pkt_ctl == CtlEnd) begin
                                commit_ptr_d = wr_ptr_q + PtrOne;
                                commit       = 1'b1;
                                state_d      = StIdle;
                            end
                        end
                    end else if (in_pkt_ctl == CtlStart || in_pkt_ctl == CtlSingle) begin
                        // Truncated packet: discard it, then treat this beat as fresh.
                        wr_ptr_d = commit_ptr_q;
                        drop_inc = 2'd1;
                        restart  = 1'b1;
                    end else begin
                        wr_ptr_d = commit_ptr_q;
                        drop_inc = 2'd1;
                        state_d  = StDiscard;
                    end
                end
                StDiscard: begin
                    if (in_pkt_ctl == CtlStart || in_pkt_ctl == CtlSingle) begin
                        restart = 1'b1;
                    end else if (in_pkt_ctl == CtlEnd) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            // Idle-style handling; wr_ptr equals commit_ptr here (or has just been rewound).
            if (restart) begin
                wr_addr = commit_ptr_q;
                if (in_pkt_ctl == CtlStart) begin
                    if (full_at_commit) begin
                        wr_ptr_d = commit_ptr_q;
                        drop_inc = drop_inc + 2'd1;
                        state_d  = StDiscard;
                    end else begin
                        wr_en      = 1'b1;
                        wr_ptr_d   = commit_ptr_q + PtrOne;
                        beat_cnt_d = CntOne;
                        state_d    = StInPkt;
                    end
                end else if (in_pkt_ctl == CtlSingle) begin
                    state_d = StIdle;
                    if (full_at_commit) begin
                        wr_ptr_d = commit_ptr_q;
                        drop_inc = drop_inc + 2'd1;
                    end else begin
                        wr_en        = 1'b1;
                        wr_ptr_d     = commit_ptr_q + PtrOne;
                        commit_ptr_d = commit_ptr_q + PtrOne;
                        commit       = 1'b1;
                    end
                end else begin
                    // Stray payload/end or unknown code outside a packet.
                    wr_ptr_d = commit_ptr_q;
                    drop_inc = drop_inc + 2'd1;
                    state_d  = StIdle;
                end
            end
        end
    end

    // Write-side state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // Buffer write port.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_addr[AW-1:0]] <= {in_pkt_ctl, in_pkt_data};
        end
    end

    // Read pointer and read-stage valid: one committed beat per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= !rd_empty;
            if (!rd_empty) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

    // Registered buffer read; qualified by rd_valid_q so it needs no reset.
    always_ff @(posedge clk) begin
        if (!rd_empty) begin
            rd_beat_q <= mem[rd_ptr_q[AW-1:0]];
        end
    end

    // Output register stage; data holds its last value when nothing is emitted.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_pkt_fifo <= 1'b0;
            out_pkt_ctl_fifo   <= 8'h00;
            out_pkt_data_fifo  <= '0;
        end else if (rd_valid_q) begin
            out_valid_pkt_fifo <= 1'b1;
            out_pkt_ctl_fifo   <= rd_beat_q[519:512];
            out_pkt_data_fifo  <= rd_beat_q[511:0];
        end else begin
            out_valid_pkt_fifo <= 1'b0;
            out_pkt_ctl_fifo   <= 8'h00;
        end
    end

`ifdef PKT_INGRESS_STATS_EN
    logic [15:0] ok_cnt_q;
    logic [15:0] drop_cnt_q;
    logic [16:0] drop_sum;

    assign drop_sum = {1'b0, drop_cnt_q} + {15'd0, drop_inc};

    // Saturating packet statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            ok_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (commit && ok_cnt_q != 16'hFFFF) begin
                ok_cnt_q <= ok_cnt_q + 16'd1;
            end
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign pkt_ok_cnt   = ok_cnt_q;
    assign pkt_drop_cnt = drop_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = ^{commit, drop_inc};

    assign pkt_ok_cnt   = 16'h0000;
    assign pkt_drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pkt_ingress_filter.sv
// tb_pkt_ingress_filter: directed scenarios plus a randomized run scored against a
// packet-level reference model (partial packet queue, committed-beat queue, counts).
module tb_pkt_ingress_filter;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned MAXB  = 8;
`ifdef PKT_INGRESS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef logic [519:0] beat_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid_pkt;
    logic [7:0]   in_pkt_ctl;
    logic [511:0] in_pkt_data;
    logic         out_valid_pkt_fifo;
    logic [7:0]   out_pkt_ctl_fifo;
    logic [511:0] out_pkt_data_fifo;
    logic [15:0]  pkt_ok_cnt;
    logic [15:0]  pkt_drop_cnt;

    logic         in2_valid;
    logic [7:0]   in2_ctl;
    logic [511:0] in2_data;
    logic         out2_valid;
    logic [7:0]   out2_ctl;
    logic [511:0] out2_data;
    logic [15:0]  ok2_cnt;
    logic [15:0]  drop2_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    pkt_ingress_filter #(.DEPTH(DEPTH), .MAX_BEATS(MAXB)) u_dut (
        .clk                (clk),
        .reset              (reset),
        .in_valid_pkt       (in_valid_pkt),
        .in_pkt_ctl         (in_pkt_ctl),
        .in_pkt_data        (in_pkt_data),
        .out_valid_pkt_fifo (out_valid_pkt_fifo),
        .out_pkt_ctl_fifo   (out_pkt_ctl_fifo),
        .out_pkt_data_fifo  (out_pkt_data_fifo),
        .pkt_ok_cnt         (pkt_ok_cnt),
        .pkt_drop_cnt       (pkt_drop_cnt)
    );

    // Second instance with a long length limit so a packet can hit the full condition.
    pkt_ingress_filter #(.DEPTH(DEPTH), .MAX_BEATS(32)) u_dut2 (
        .clk                (clk),
        .reset              (reset),
        .in_valid_pkt       (in2_valid),
        .in_pkt_ctl         (in2_ctl),
        .in_pkt_data        (in2_data),
        .out_valid_pkt_fifo (out2_valid),
        .out_pkt_ctl_fifo   (out2_ctl),
        .out_pkt_data_fifo  (out2_data),
        .pkt_ok_cnt         (ok2_cnt),
        .pkt_drop_cnt       (drop2_cnt)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Observed stream of dut 1, and output tally of dut 2.
    beat_t obs_q[$];
    int    obs_t[$];
    int    n2 = 0;
    logic [7:0]   last2_ctl;
    logic [511:0] last2_data;

    always @(negedge clk) begin
        if (out_valid_pkt_fifo === 1'b1) begin
            obs_q.push_back({out_pkt_ctl_fifo, out_pkt_data_fifo});
            obs_t.push_back(cyc);
        end
        if (out2_valid === 1'b1) begin
            n2 = n2 + 1;
            last2_ctl = out2_ctl;
            last2_data = out2_data;
        end
    end

    // Reference model: occupancy counts and packet queues, stepped once per edge.
    beat_t exp_q[$];
    beat_t part_q[$];
    int    m_mode = 0;   // 0 idle, 1 inside packet, 2 discarding
    int    m_comm = 0;   // committed beats still in the buffer
    int    m_newc = 0;
    int    m_ok = 0;
    int    m_drop = 0;

    function automatic void m_commit();
        foreach (part_q[i]) exp_q.push_back(part_q[i]);
        m_newc = m_newc + part_q.size();
        part_q.delete();
        m_ok = m_ok + 1;
    endfunction

    function automatic void m_fresh(input logic [7:0] c, input beat_t b);
        int occ;
        occ = m_comm + part_q.size();
        if (c == 8'h01) begin
            if (occ == DEPTH) begin m_drop++; m_mode = 2; end
            else begin part_q.push_back(b); m_mode = 1; end
        end else if (c == 8'h04) begin
            m_mode = 0;
            if (occ == DEPTH) m_drop++;
            else begin part_q.push_back(b); m_commit(); end
        end else begin
            m_drop++;
            m_mode = 0;
        end
    endfunction

    function automatic void m_step(input logic v, input logic [7:0] c, input logic [511:0] d);
        beat_t b;
        bit    rd;
        b = {c, d};
        rd = (m_comm > 0);
        m_newc = 0;
        if (v && c != 8'h00) begin
            if (m_mode == 0) begin
                m_fresh(c, b);
            end else if (m_mode == 1) begin
                if (c == 8'h02 || c == 8'h03) begin
                    if (part_q.size() + 1 > MAXB) begin
                        part_q.delete(); m_drop++; m_mode = (c == 8'h03) ? 0 : 2;
                    end else if (m_comm + part_q.size() == DEPTH) begin
                        part_q.delete(); m_drop++; m_mode = 2;
                    end else begin
                        part_q.push_back(b);
                        if (c == 8'h03) begin m_commit(); m_mode = 0; end
                    end
                end else if (c == 8'h01 || c == 8'h04) begin
                    part_q.delete(); m_drop++;
                    m_fresh(c, b);
                end else begin
                    part_q.delete(); m_drop++; m_mode = 2;
                end
            end else begin
                if (c == 8'h01 || c == 8'h04) m_fresh(c, b);
                else if (c == 8'h03) m_mode = 0;
            end
        end
        m_comm = m_comm - (rd ? 1 : 0) + m_newc;
    endfunction

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            for (int i = 0; i < m_comm; i++) void'(exp_q.pop_back());
            part_q.delete();
            m_mode = 0; m_comm = 0; m_ok = 0; m_drop = 0;
        end else begin
            m_step(in_valid_pkt, in_pkt_ctl, in_pkt_data);
        end
    end

    function automatic logic [15:0] want_cnt(input int n);
        if (!STATS) return 16'h0000;
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic drive(input logic [7:0] c, input logic [511:0] d);
        @(negedge clk);
        in_valid_pkt = 1'b1; in_pkt_ctl = c; in_pkt_data = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid_pkt = 1'b0; in_pkt_ctl = 8'h00;
        end
    endtask

    task automatic drive2(input logic [7:0] c, input logic [511:0] d);
        @(negedge clk);
        in2_valid = 1'b1; in2_ctl = c; in2_data = d;
    endtask

    task automatic idle2(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in2_valid = 1'b0; in2_ctl = 8'h00;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid_pkt = 1'b0; in_pkt_ctl = 8'h00;
        in2_valid = 1'b0; in2_ctl = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid_pkt = 1'b1; in_pkt_ctl = 8'h04; in_pkt_data = 512'h55;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid_pkt_fifo !== 1'b0) begin n_fail++;
            $display("FAIL reset_valid: got %b want 0", out_valid_pkt_fifo); end
        n_cmp++; if (out_pkt_ctl_fifo !== 8'h00) begin n_fail++;
            $display("FAIL reset_ctl: got %h want 00", out_pkt_ctl_fifo); end
        n_cmp++; if (out_pkt_data_fifo !== 512'h0) begin n_fail++;
            $display("FAIL reset_data: got %h want 0", out_pkt_data_fifo); end
        n_cmp++; if (pkt_ok_cnt !== 16'h0 || pkt_drop_cnt !== 16'h0) begin n_fail++;
            $display("FAIL reset_cnt: got ok=%0d drop=%0d want 0/0", pkt_ok_cnt, pkt_drop_cnt); end
        n_cmp++; if (out2_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_valid2: got %b want 0", out2_valid); end
        @(negedge clk);
        in_valid_pkt = 1'b0; in_pkt_ctl = 8'h00;
        reset = 1'b0;
        idle(4);
        n_cmp++; if (out_valid_pkt_fifo !== 1'b0) begin n_fail++;
            $display("FAIL reset_priority: got valid %b want 0", out_valid_pkt_fifo); end
    endtask

    task automatic test_single();
        logic [511:0] d;
        d = 512'hAB;
        do_reset();
        drive(8'h04, d);
        @(posedge clk); #1;  // edge k samples the beat
        in_valid_pkt = 1'b0; in_pkt_ctl = 8'h00;
        n_cmp++; if (out_valid_pkt_fifo !== 1'b0) begin n_fail++;
            $display("FAIL single_k: got valid %b want 0", out_valid_pkt_fifo); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid_pkt_fifo !== 1'b0) begin n_fail++;
            $display("FAIL single_k1: got valid %b want 0", out_valid_pkt_fifo); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid_pkt_fifo !== 1'b1 || out_pkt_ctl_fifo !== 8'h04) begin n_fail++;
            $display("FAIL single_k2: got valid %b ctl %h want 1/04",
                     out_valid_pkt_fifo, out_pkt_ctl_fifo); end
        n_cmp++; if (out_pkt_data_fifo !== d) begin n_fail++;
            $display("FAIL single_data: got %h want %h", out_pkt_data_fifo, d); end
        n_cmp++; if (pkt_ok_cnt !== want_cnt(1)) begin n_fail++;
            $display("FAIL single_ok: got %0d want %0d", pkt_ok_cnt, want_cnt(1)); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid_pkt_fifo !== 1'b0 || out_pkt_ctl_fifo !== 8'h00) begin n_fail++;
            $display("FAIL single_idle: got valid %b ctl %h want 0/00",
                     out_valid_pkt_fifo, out_pkt_ctl_fifo); end
        n_cmp++; if (out_pkt_data_fifo !== d) begin n_fail++;
            $display("FAIL single_hold: got %h want %h", out_pkt_data_fifo, d); end
        idle(4);
    endtask

    task automatic test_alternate();
        logic [511:0] d0, d1;
        int base;
        d0 = rnd512(); d1 = rnd512();
        do_reset();
        base = obs_q.size();
        drive(8'h01, d0); idle(1);
        drive(8'h03, d1); idle(10);
        n_cmp++; if (obs_q.size() - base != 2) begin n_fail++;
            $display("FAIL alt_count: got %0d want 2", obs_q.size() - base); end
        else begin
            n_cmp++; if (obs_q[base] !== {8'h01, d0}) begin n_fail++;
                $display("FAIL alt_beat0: got %h want %h", obs_q[base], {8'h01, d0}); end
            n_cmp++; if (obs_q[base+1] !== {8'h03, d1}) begin n_fail++;
                $display("FAIL alt_beat1: got %h want %h", obs_q[base+1], {8'h03, d1}); end
            n_cmp++; if (obs_t[base+1] - obs_t[base] != 1) begin n_fail++;
                $display("FAIL alt_b2b: got gap %0d want 1", obs_t[base+1] - obs_t[base]); end
        end
    endtask

    task automatic test_max_len();
        beat_t want[$];
        logic [511:0] d;
        int base;
        do_reset();
        base = obs_q.size();
        for (int i = 0; i < 8; i++) begin
            d = rnd512();
            if (i == 0) begin drive(8'h01, d); want.push_back({8'h01, d}); end
            else if (i == 7) begin drive(8'h03, d); want.push_back({8'h03, d}); end
            else begin drive(8'h02, d); want.push_back({8'h02, d}); end
        end
        for (int i = 0; i < 9; i++) begin
            drive((i == 0) ? 8'h01 : ((i == 8) ? 8'h03 : 8'h02), rnd512());
        end
        idle(20);
        n_cmp++; if (obs_q.size() - base != 8) begin n_fail++;
            $display("FAIL maxlen_count: got %0d want 8", obs_q.size() - base); end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++; if (obs_q[base+i] !== want[i]) begin n_fail++;
                    $display("FAIL maxlen_beat%0d: got %h want %h", i, obs_q[base+i], want[i]); end
            end
        end
        n_cmp++; if (pkt_ok_cnt !== want_cnt(1) || pkt_drop_cnt !== want_cnt(1)) begin n_fail++;
            $display("FAIL maxlen_cnt: got ok=%0d drop=%0d want %0d/%0d",
                     pkt_ok_cnt, pkt_drop_cnt, want_cnt(1), want_cnt(1)); end
        // A stray payload only counts if the filter went back to idle after the end beat.
        drive(8'h02, rnd512()); idle(3);
        n_cmp++; if (pkt_drop_cnt !== want_cnt(2)) begin n_fail++;
            $display("FAIL maxlen_idle: got drop=%0d want %0d", pkt_drop_cnt, want_cnt(2)); end
    endtask

    task automatic test_stray();
        logic [511:0] a, b, c;
        int base;
        a = rnd512(); b = rnd512(); c = rnd512();
        do_reset();
        base = obs_q.size();
        drive(8'h03, rnd512());
        drive(8'h01, a);
        drive(8'h01, b);
        drive(8'h03, c);
        idle(10);
        n_cmp++; if (obs_q.size() - base != 2) begin n_fail++;
            $display("FAIL stray_count: got %0d want 2", obs_q.size() - base); end
        else begin
            n_cmp++; if (obs_q[base] !== {8'h01, b} || obs_q[base+1] !== {8'h03, c}) begin
                n_fail++;
                $display("FAIL stray_beats: got %h / %h want %h / %h", obs_q[base],
                         obs_q[base+1], {8'h01, b}, {8'h03, c}); end
        end
        n_cmp++; if (pkt_drop_cnt !== want_cnt(2) || pkt_ok_cnt !== want_cnt(1)) begin n_fail++;
            $display("FAIL stray_cnt: got ok=%0d drop=%0d want %0d/%0d",
                     pkt_ok_cnt, pkt_drop_cnt, want_cnt(1), want_cnt(2)); end
    endtask

    task automatic test_flood();
        logic [511:0] ds[17];
        int base;
        int bad_data, bad_gap;
        do_reset();
        base = obs_q.size();
        for (int i = 0; i < 17; i++) begin
            ds[i] = rnd512();
            drive(8'h04, ds[i]);
        end
        idle(25);
        n_cmp++; if (obs_q.size() - base != 17) begin n_fail++;
            $display("FAIL flood_count: got %0d want 17", obs_q.size() - base); end
        else begin
            bad_data = 0; bad_gap = 0;
            for (int i = 0; i < 17; i++) begin
                if (obs_q[base+i] !== {8'h04, ds[i]}) bad_data++;
                if (obs_t[base+i] - obs_t[base] != i) bad_gap++;
            end
            n_cmp++; if (bad_data != 0) begin n_fail++;
                $display("FAIL flood_order: got %0d wrong beats want 0", bad_data); end
            n_cmp++; if (bad_gap != 0) begin n_fail++;
                $display("FAIL flood_b2b: got %0d gaps want 0", bad_gap); end
        end
        n_cmp++; if (pkt_ok_cnt !== want_cnt(17)) begin n_fail++;
            $display("FAIL flood_ok: got %0d want %0d", pkt_ok_cnt, want_cnt(17)); end
    endtask

    task automatic test_full_drop();
        logic [511:0] d;
        int base2;
        do_reset();
        base2 = n2;
        for (int i = 0; i < 20; i++) begin
            drive2((i == 0) ? 8'h01 : ((i == 19) ? 8'h03 : 8'h02), rnd512());
        end
        idle2(10);
        n_cmp++; if (n2 != base2) begin n_fail++;
            $display("FAIL full_emit: got %0d beats want 0", n2 - base2); end
        n_cmp++; if (drop2_cnt !== want_cnt(1) || ok2_cnt !== want_cnt(0)) begin n_fail++;
            $display("FAIL full_cnt: got ok=%0d drop=%0d want %0d/%0d",
                     ok2_cnt, drop2_cnt, want_cnt(0), want_cnt(1)); end
        d = rnd512();
        drive2(8'h04, d); idle2(6);
        n_cmp++; if (n2 - base2 != 1 || last2_ctl !== 8'h04 || last2_data !== d) begin n_fail++;
            $display("FAIL full_recover: got %0d beats ctl %h want 1 beat ctl 04",
                     n2 - base2, last2_ctl); end
        n_cmp++; if (ok2_cnt !== want_cnt(1)) begin n_fail++;
            $display("FAIL full_ok: got %0d want %0d", ok2_cnt, want_cnt(1)); end
    endtask

    task automatic test_reset_mid();
        logic [511:0] d;
        int base;
        do_reset();
        base = obs_q.size();
        drive(8'h01, rnd512());
        drive(8'h02, rnd512());
        @(negedge clk);
        reset = 1'b1;
        in_valid_pkt = 1'b1; in_pkt_ctl = 8'h04; in_pkt_data = rnd512();
        @(negedge clk);
        reset = 1'b0;
        in_valid_pkt = 1'b0; in_pkt_ctl = 8'h00;
        idle(10);
        n_cmp++; if (obs_q.size() != base) begin n_fail++;
            $display("FAIL rstmid_emit: got %0d beats want 0", obs_q.size() - base); end
        d = rnd512();
        drive(8'h04, d); idle(6);
        n_cmp++; if (obs_q.size() - base != 1) begin n_fail++;
            $display("FAIL rstmid_count: got %0d want 1", obs_q.size() - base); end
        else begin
            n_cmp++; if (obs_q[base] !== {8'h04, d}) begin n_fail++;
                $display("FAIL rstmid_beat: got %h want %h", obs_q[base], {8'h04, d}); end
        end
        n_cmp++; if (pkt_ok_cnt !== want_cnt(1) || pkt_drop_cnt !== want_cnt(0)) begin n_fail++;
            $display("FAIL rstmid_cnt: got ok=%0d drop=%0d want %0d/0",
                     pkt_ok_cnt, pkt_drop_cnt, want_cnt(1)); end
    endtask

    task automatic test_random();
        int base_o, base_e, n_o, n_e, r, bad;
        do_reset();
        base_o = obs_q.size();
        base_e = exp_q.size();
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            r = $urandom_range(0, 99);
            in_valid_pkt = (r >= 8);
            in_pkt_data = rnd512();
            if (r < 14)      in_pkt_ctl = 8'h00;
            else if (r < 34) in_pkt_ctl = 8'h01;
            else if (r < 72) in_pkt_ctl = 8'h02;
            else if (r < 88) in_pkt_ctl = 8'h03;
            else if (r < 96) in_pkt_ctl = 8'h04;
            else             in_pkt_ctl = 8'($urandom_range(5, 255));
        end
        idle(30);
        n_o = obs_q.size() - base_o;
        n_e = exp_q.size() - base_e;
        n_cmp++; if (n_o != n_e) begin n_fail++;
            $display("FAIL rand_count: got %0d beats want %0d", n_o, n_e); end
        bad = 0;
        for (int i = 0; i < n_o && i < n_e; i++) begin
            if (obs_q[base_o+i] !== exp_q[base_e+i]) begin
                if (bad == 0) $display("FAIL rand_beat%0d: got %h want %h", i,
                                       obs_q[base_o+i], exp_q[base_e+i]);
                bad++;
            end
        end
        n_cmp++; if (bad != 0) begin n_fail++;
            $display("FAIL rand_stream: got %0d wrong beats want 0", bad); end
        n_cmp++; if (pkt_ok_cnt !== want_cnt(m_ok)) begin n_fail++;
            $display("FAIL rand_ok: got %0d want %0d", pkt_ok_cnt, want_cnt(m_ok)); end
        n_cmp++; if (pkt_drop_cnt !== want_cnt(m_drop)) begin n_fail++;
            $display("FAIL rand_drop: got %0d want %0d", pkt_drop_cnt, want_cnt(m_drop)); end
    endtask

    initial begin
        reset = 1'b1;
        in_valid_pkt = 1'b0; in_pkt_ctl = 8'h00; in_pkt_data = '0;
        in2_valid = 1'b0; in2_ctl = 8'h00; in2_data = '0;
        test_reset();
        test_single();
        test_alternate();
        test_max_len();
        test_stray();
        test_flood();
        test_full_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
